// File: rtl/exc_pkg.sv
// Shared definitions for the MEM-stage exception controller: flag bit indices,
// ExcCode values, NPC entry selector, FSM states and the CP0 commit record.
package exc_pkg;

    localparam int EXC_IF_ADEL     = 0;
    localparam int EXC_IF_REFILL   = 1;
    localparam int EXC_IF_TLB_INV  = 2;
    localparam int EXC_RI          = 3;
    localparam int EXC_OV          = 4;
    localparam int EXC_TR          = 5;
    localparam int EXC_SYS         = 6;
    localparam int EXC_BP          = 7;
    localparam int EXC_ERET        = 8;
    localparam int EXC_MEM_ADEL    = 9;
    localparam int EXC_ADES        = 10;
    localparam int EXC_TLBL_REFILL = 11;
    localparam int EXC_TLBS_REFILL = 12;
    localparam int EXC_TLBL_INV    = 13;
    localparam int EXC_TLBS_INV    = 14;
    localparam int EXC_MOD         = 15;
    localparam int EXC_FIXED_NUM   = 16;

    localparam logic [4:0] CODE_INT  = 5'd0;
    localparam logic [4:0] CODE_MOD  = 5'd1;
    localparam logic [4:0] CODE_TLBL = 5'd2;
    localparam logic [4:0] CODE_TLBS = 5'd3;
    localparam logic [4:0] CODE_ADEL = 5'd4;
    localparam logic [4:0] CODE_ADES = 5'd5;
    localparam logic [4:0] CODE_SYS  = 5'd8;
    localparam logic [4:0] CODE_BP   = 5'd9;
    localparam logic [4:0] CODE_RI   = 5'd10;
    localparam logic [4:0] CODE_OV   = 5'd12;
    localparam logic [4:0] CODE_TR   = 5'd13;

    typedef enum logic [2:0] {
        ENTRY_NONE    = 3'd0,
        ENTRY_EXC     = 3'd1,
        ENTRY_REFILL  = 3'd2,
        ENTRY_ERET    = 3'd3,
        ENTRY_REFETCH = 3'd4
    } entry_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COMMIT = 2'd1,
        ST_DRAIN  = 2'd2
    } exc_state_e;

    typedef struct packed {
        logic [4:0]  code;
        logic [31:0] epc;
        logic        bd;
        logic [31:0] badvaddr;
        logic        badv_we;
        logic        eret;
    } exc_record_t;

    // ERET carries no ExcCode; it reports 0 alongside the eret flag.
    function automatic logic [4:0] fixed_code(input int idx);
        case (idx)
            EXC_IF_ADEL, EXC_MEM_ADEL:                       fixed_code = CODE_ADEL;
            EXC_IF_REFILL, EXC_IF_TLB_INV,
            EXC_TLBL_REFILL, EXC_TLBL_INV:                   fixed_code = CODE_TLBL;
            EXC_TLBS_REFILL, EXC_TLBS_INV:                   fixed_code = CODE_TLBS;
            EXC_RI:                                          fixed_code = CODE_RI;
            EXC_OV:                                          fixed_code = CODE_OV;
            EXC_TR:                                          fixed_code = CODE_TR;
            EXC_SYS:                                         fixed_code = CODE_SYS;
            EXC_BP:                                          fixed_code = CODE_BP;
            EXC_ADES:                                        fixed_code = CODE_ADES;
            EXC_MOD:                                         fixed_code = CODE_MOD;
            default:                                         fixed_code = CODE_INT;
        endcase
    endfunction

endpackage

// File: rtl/exception_ctrl_if.sv
// Pipeline/CP0 side bundle of the exception controller; master drives the MEM
// stage and CP0 state, slave is the controller itself.
interface exception_ctrl_if #(
    parameter int NUM_EXC = 16,
    parameter int HW_INT  = 6
);
    logic               mem_valid;
    logic               mem_stall;
    logic [31:0]        mem_pc;
    logic               mem_bd;
    logic [31:0]        mem_badvaddr;
    logic [NUM_EXC-1:0] mem_exc_vec;
    logic [HW_INT-1:0]  hw_int_async;
    logic [1:0]         cp0_ip_sw;
    logic [7:0]         cp0_im;
    logic               cp0_exl;
    logic               cp0_ie;
    logic               cp0_ack;
    logic               commit_valid;
    logic [4:0]         commit_code;
    logic [31:0]        commit_epc;
    logic               commit_bd;
    logic [31:0]        commit_badvaddr;
    logic               commit_badv_we;
    logic               commit_eret;
    logic               flush_id;
    logic               flush_exe;
    logic               flush_mem;
    logic               regwr_kill;
    logic [2:0]         entry_sel;
    logic [HW_INT-1:0]  hw_int_sync;
    logic               int_pending;
    logic [31:0]        perf_exc_cnt;
    logic [31:0]        perf_int_cnt;

    modport master (
        output mem_valid, mem_stall, mem_pc, mem_bd, mem_badvaddr, mem_exc_vec,
               hw_int_async, cp0_ip_sw, cp0_im, cp0_exl, cp0_ie, cp0_ack,
        input  commit_valid, commit_code, commit_epc, commit_bd, commit_badvaddr,
               commit_badv_we, commit_eret, flush_id, flush_exe, flush_mem,
               regwr_kill, entry_sel, hw_int_sync, int_pending, perf_exc_cnt,
               perf_int_cnt
    );

    modport slave (
        input  mem_valid, mem_stall, mem_pc, mem_bd, mem_badvaddr, mem_exc_vec,
               hw_int_async, cp0_ip_sw, cp0_im, cp0_exl, cp0_ie, cp0_ack,
        output commit_valid, commit_code, commit_epc, commit_bd, commit_badvaddr,
               commit_badv_we, commit_eret, flush_id, flush_exe, flush_mem,
               regwr_kill, entry_sel, hw_int_sync, int_pending, perf_exc_cnt,
               perf_int_cnt
    );
endinterface

// File: rtl/exception_ctrl_int_sync.sv
// Per-line multi-flop synchroniser for the asynchronous hardware interrupt inputs.
module int_sync #(
    parameter int WIDTH  = 6,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o
);
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_line
        logic [STAGES-1:0] chain_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                chain_q <= '0;
            end else begin
                chain_q <= {chain_q[STAGES-2:0], async_i[gi]};
            end
        end

        assign sync_o[gi] = chain_q[STAGES-1];
    end
endmodule

// File: rtl/exception_ctrl.sv
// MEM-stage exception controller: picks the winning exception, flushes the pipe,
// hands a commit record to CP0 and holds the flush for a drain window.
// Optional event counters are built when EXC_PERF_CNT_EN is defined.
module exception_ctrl
    import exc_pkg::*;
#(
    parameter int         NUM_EXC      = 16,
    parameter int         HW_INT       = 6,
    parameter int         SYNC_STAGES  = 2,
    parameter int         FLUSH_CYCLES = 2,
    parameter logic [4:0] EXT_EXC_CODE = 5'h1E
) (
    input logic             clk,
    input logic             rst,
    exception_ctrl_if.slave bus
);
    localparam bit HAS_REFETCH = (NUM_EXC > EXC_FIXED_NUM);
    localparam int REFETCH_IDX = NUM_EXC - 1;
    localparam int CNT_W       = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    exc_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    exc_record_t       rec_q;
    exc_record_t       rec_d;
    entry_sel_e        win_entry;
    logic              refetch_win;
    logic              any_exc;
    int                win_idx;
    logic [HW_INT-1:0] hw_sync;
    logic [7:0]        ip_all;
    logic              int_pending;
    logic              take;

    int_sync #(.WIDTH(HW_INT), .STAGES(SYNC_STAGES)) u_int_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (bus.hw_int_async),
        .sync_o  (hw_sync)
    );

    assign ip_all      = 8'({hw_sync, bus.cp0_ip_sw});
    assign int_pending = (|(ip_all & bus.cp0_im)) & ~bus.cp0_exl & bus.cp0_ie;

    // Descending scan so the lowest set index (highest priority) wins.
    always_comb begin
        any_exc = 1'b0;
        win_idx = 0;
        for (int i = NUM_EXC - 1; i >= 0; i--) begin
            if (bus.mem_exc_vec[i]) begin
                any_exc = 1'b1;
                win_idx = i;
            end
        end
    end

    always_comb begin
        rec_d       = '0;
        rec_d.epc   = bus.mem_bd ? (bus.mem_pc - 32'd4) : bus.mem_pc;
        rec_d.bd    = bus.mem_bd;
        win_entry   = ENTRY_EXC;
        refetch_win = 1'b0;
        if (int_pending) begin
            rec_d.code = CODE_INT;
        end else if (HAS_REFETCH && win_idx == REFETCH_IDX) begin
            win_entry   = ENTRY_REFETCH;
            refetch_win = 1'b1;
        end else if (win_idx < EXC_FIXED_NUM) begin
            rec_d.code = fixed_code(win_idx);
            if (win_idx == EXC_IF_REFILL || win_idx == EXC_TLBL_REFILL ||
                win_idx == EXC_TLBS_REFILL) begin
                win_entry = ENTRY_REFILL;
            end else if (win_idx == EXC_ERET) begin
                win_entry  = ENTRY_ERET;
                rec_d.eret = 1'b1;
            end
            if (win_idx <= EXC_IF_TLB_INV) begin
                rec_d.badv_we  = 1'b1;
                rec_d.badvaddr = bus.mem_pc;
            end else if (win_idx >= EXC_MEM_ADEL) begin
                rec_d.badv_we  = 1'b1;
                rec_d.badvaddr = bus.mem_badvaddr;
            end
        end else begin
            rec_d.code = EXT_EXC_CODE;
        end
    end

    assign take = (state_q == ST_IDLE) & bus.mem_valid & ~bus.mem_stall &
                  (int_pending | any_exc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rec_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (take) begin
                        rec_q <= rec_d;
                        if (refetch_win) begin
                            state_q <= ST_DRAIN;
                            cnt_q   <= CNT_LOAD;
                        end else begin
                            state_q <= ST_COMMIT;
                        end
                    end
                end
                ST_COMMIT: begin
                    if (bus.cp0_ack) begin
                        state_q <= ST_DRAIN;
                        cnt_q   <= CNT_LOAD;
                    end
                end
                ST_DRAIN: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.commit_valid    = (state_q == ST_COMMIT);
    assign bus.commit_code     = rec_q.code;
    assign bus.commit_epc      = rec_q.epc;
    assign bus.commit_bd       = rec_q.bd;
    assign bus.commit_badvaddr = rec_q.badvaddr;
    assign bus.commit_badv_we  = rec_q.badv_we;
    assign bus.commit_eret     = rec_q.eret;
    assign bus.flush_id        = take | (state_q != ST_IDLE);
    assign bus.flush_exe       = take | (state_q != ST_IDLE);
    assign bus.flush_mem       = take | (state_q != ST_IDLE);
    assign bus.regwr_kill      = take | (state_q != ST_IDLE);
    assign bus.entry_sel       = take ? win_entry : ENTRY_NONE;
    assign bus.hw_int_sync     = hw_sync;
    assign bus.int_pending     = int_pending;

`ifdef EXC_PERF_CNT_EN
    logic [31:0] perf_exc_q;
    logic [31:0] perf_int_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_exc_q <= '0;
            perf_int_q <= '0;
        end else if (take) begin
            if (int_pending) perf_int_q <= perf_int_q + 32'd1;
            else             perf_exc_q <= perf_exc_q + 32'd1;
        end
    end

    assign bus.perf_exc_cnt = perf_exc_q;
    assign bus.perf_int_cnt = perf_int_q;
`else
    assign bus.perf_exc_cnt = '0;
    assign bus.perf_int_cnt = '0;
`endif

endmodule

// File: tb/tb_exception_ctrl.sv
// Self-checking bench for exception_ctrl (built with a refetch slot, NUM_EXC=17).
module tb_exception_ctrl;
    localparam int NEXC = 17;
    localparam int HWI  = 6;
    localparam int FC   = 2;
    localparam int CODE_TBL [16] = '{4, 2, 2, 10, 12, 13, 8, 9, 0, 4, 5, 2, 3, 2, 3, 1};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    exception_ctrl_if #(.NUM_EXC(NEXC), .HW_INT(HWI)) bus ();

    exception_ctrl #(
        .NUM_EXC(NEXC), .HW_INT(HWI), .SYNC_STAGES(2),
        .FLUSH_CYCLES(FC), .EXT_EXC_CODE(5'h1E)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int vectors = 0;
    int errors  = 0;
    int exp_exc_cnt = 0;
    int exp_int_cnt = 0;
    logic [HWI-1:0] hw_level = '0;
    logic [7:0]     im_v  = 8'h00;
    logic           ie_v  = 1'b0;
    logic           exl_v = 1'b0;

    // Behavioural reference: priority and field rules straight from the ExcCode table.
    function automatic void ref_model(
        input  logic [NEXC-1:0] vec, input logic intp, input logic [31:0] pc,
        input  logic bd, input logic [31:0] badv,
        output logic [2:0] entry, output logic [4:0] code, output logic [31:0] epc,
        output logic [31:0] bva, output logic bwe, output logic eret);
        int w;
        epc = bd ? pc - 32'd4 : pc;
        entry = 3'd1; code = 5'd0; bva = 32'd0; bwe = 1'b0; eret = 1'b0;
        if (intp) return;
        w = -1;
        for (int i = 0; i < NEXC; i++) if (vec[i] && w < 0) w = i;
        if (w == NEXC - 1) begin
            entry = 3'd4;
            return;
        end
        code = 5'(CODE_TBL[w]);
        if (w == 1 || w == 11 || w == 12) entry = 3'd2;
        if (w == 8) begin entry = 3'd3; eret = 1'b1; end
        if (w <= 2) begin bwe = 1'b1; bva = pc; end
        if (w >= 9) begin bwe = 1'b1; bva = badv; end
    endfunction

    task automatic run_txn(input string name, input logic [NEXC-1:0] vec, input logic [31:0] pc,
                           input logic bd, input logic [31:0] badv, input logic [1:0] ipsw,
                           input int ackd);
        logic [2:0] e_entry; logic [4:0] e_code; logic [31:0] e_epc, e_bva;
        logic e_bwe, e_eret, intp;
        intp = (|({hw_level, ipsw} & im_v)) & ie_v & ~exl_v;
        ref_model(vec, intp, pc, bd, badv, e_entry, e_code, e_epc, e_bva, e_bwe, e_eret);
        @(posedge clk); #1;
        bus.mem_valid = 1'b1; bus.mem_stall = 1'b0; bus.mem_exc_vec = vec;
        bus.mem_pc = pc; bus.mem_bd = bd; bus.mem_badvaddr = badv;
        bus.cp0_ip_sw = ipsw; bus.cp0_im = im_v; bus.cp0_ie = ie_v; bus.cp0_exl = exl_v;
        @(negedge clk);
        vectors++;
        if ({bus.flush_id, bus.flush_exe, bus.flush_mem, bus.regwr_kill} !== 4'hF) begin
            errors++;
            $display("FAIL %s take_flush got=%b want=1111", name,
                     {bus.flush_id, bus.flush_exe, bus.flush_mem, bus.regwr_kill});
        end
        vectors++;
        if (bus.entry_sel !== e_entry) begin
            errors++;
            $display("FAIL %s entry_sel got=%0d want=%0d", name, bus.entry_sel, e_entry);
        end
        if (intp) exp_int_cnt++; else exp_exc_cnt++;
        @(posedge clk); #1;
        bus.mem_valid = 1'b0; bus.mem_exc_vec = '0; bus.cp0_ip_sw = 2'b00;
        if (e_entry != 3'd4) begin
            for (int d = 0; d <= ackd; d++) begin
                if (d > 0) begin @(posedge clk); #1; end
                bus.cp0_ack = (d == ackd);
                @(negedge clk);
                vectors++;
                if (bus.commit_valid !== 1'b1 || bus.flush_mem !== 1'b1 || bus.entry_sel !== 3'd0) begin
                    errors++;
                    $display("FAIL %s commit_hold got valid=%b flush=%b entry=%0d want 1/1/0",
                             name, bus.commit_valid, bus.flush_mem, bus.entry_sel);
                end
                vectors++;
                if (bus.commit_code !== e_code || bus.commit_epc !== e_epc || bus.commit_bd !== bd ||
                    bus.commit_badv_we !== e_bwe || bus.commit_eret !== e_eret ||
                    (e_bwe && bus.commit_badvaddr !== e_bva)) begin
                    errors++;
                    $display("FAIL %s record got code=%0d epc=%h bd=%b bva=%h we=%b eret=%b want code=%0d epc=%h bd=%b bva=%h we=%b eret=%b",
                             name, bus.commit_code, bus.commit_epc, bus.commit_bd, bus.commit_badvaddr,
                             bus.commit_badv_we, bus.commit_eret, e_code, e_epc, bd, e_bva, e_bwe, e_eret);
                end
            end
            @(posedge clk); #1;
            bus.cp0_ack = 1'b0;
        end
        for (int k = 0; k < FC; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            @(negedge clk);
            vectors++;
            if (bus.flush_mem !== 1'b1 || bus.flush_id !== 1'b1 || bus.commit_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s drain%0d got flush=%b valid=%b want 1/0", name, k,
                         bus.flush_mem, bus.commit_valid);
            end
        end
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if (bus.flush_mem !== 1'b0 || bus.entry_sel !== 3'd0 || bus.commit_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s back_to_idle got flush=%b entry=%0d valid=%b want 0/0/0", name,
                     bus.flush_mem, bus.entry_sel, bus.commit_valid);
        end
        $display("txn %s vec=%h pc=%h bd=%b int=%b entry=%0d code=%0d ack_delay=%0d",
                 name, vec, pc, bd, intp, e_entry, e_code, ackd);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.mem_valid = 0; bus.mem_stall = 0; bus.mem_pc = '0; bus.mem_bd = 0;
        bus.mem_badvaddr = '0; bus.mem_exc_vec = '0; bus.hw_int_async = '0;
        bus.cp0_ip_sw = '0; bus.cp0_im = '0; bus.cp0_exl = 0; bus.cp0_ie = 0; bus.cp0_ack = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (bus.commit_valid !== 1'b0 || bus.entry_sel !== 3'd0 || bus.flush_mem !== 1'b0 ||
            bus.flush_id !== 1'b0 || bus.regwr_kill !== 1'b0 || bus.int_pending !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl got valid=%b entry=%0d flush=%b kill=%b intp=%b want all 0",
                     bus.commit_valid, bus.entry_sel, bus.flush_mem, bus.regwr_kill, bus.int_pending);
        end
        vectors++;
        if (bus.commit_code !== 5'd0 || bus.commit_epc !== 32'd0 || bus.hw_int_sync !== '0 ||
            bus.perf_exc_cnt !== 32'd0 || bus.perf_int_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_data got code=%0d epc=%h sync=%b perf=%0d/%0d want 0",
                     bus.commit_code, bus.commit_epc, bus.hw_int_sync, bus.perf_exc_cnt, bus.perf_int_cnt);
        end
        rst = 1'b0;
        $display("txn reset released");
    endtask

    task automatic test_stall_and_reset();
        @(posedge clk); #1;
        bus.mem_valid = 1'b1; bus.mem_stall = 1'b1; bus.mem_exc_vec = NEXC'(1) << 7;
        bus.mem_pc = 32'h8000_2000; bus.mem_bd = 1'b0; bus.cp0_im = 8'h00;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if (bus.flush_mem !== 1'b0 || bus.entry_sel !== 3'd0) begin
                errors++;
                $display("FAIL stall_cycle%0d got flush=%b entry=%0d want 0/0", c,
                         bus.flush_mem, bus.entry_sel);
            end
            @(posedge clk); #1;
        end
        bus.mem_stall = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.flush_mem !== 1'b1 || bus.entry_sel !== 3'd1) begin
            errors++;
            $display("FAIL stall_release got flush=%b entry=%0d want 1/1", bus.flush_mem, bus.entry_sel);
        end
        @(posedge clk); #1;
        bus.mem_valid = 1'b0; bus.mem_exc_vec = '0;
        @(negedge clk);
        vectors++;
        if (bus.commit_valid !== 1'b1 || bus.commit_code !== 5'd9) begin
            errors++;
            $display("FAIL stall_commit got valid=%b code=%0d want 1/9", bus.commit_valid, bus.commit_code);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (bus.commit_valid !== 1'b0 || bus.entry_sel !== 3'd0 || bus.flush_mem !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got valid=%b entry=%0d flush=%b want 0/0/0",
                     bus.commit_valid, bus.entry_sel, bus.flush_mem);
        end
        exp_exc_cnt = 0; exp_int_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        $display("txn stall then reset mid-commit");
    endtask

    task automatic test_int_sync();
        im_v = 8'h04; ie_v = 1'b1; exl_v = 1'b0;
        @(posedge clk); #1;
        bus.cp0_im = im_v; bus.cp0_ie = ie_v; bus.cp0_exl = exl_v;
        bus.hw_int_async = HWI'(1);
        for (int e = 0; e < 3; e++) begin
            if (e > 0) begin @(posedge clk); #1; end
            @(negedge clk);
            vectors++;
            if (bus.int_pending !== (e == 2)) begin
                errors++;
                $display("FAIL int_sync_edge%0d got=%b want=%b", e, bus.int_pending, (e == 2));
            end
        end
        hw_level = HWI'(1);
        $display("txn hw_int[0] synchronised after 2 edges");
        run_txn("int_over_sys", NEXC'(1) << 6, 32'h8000_3000, 1'b0, 32'h0, 2'b00, 1);
        bus.hw_int_async = '0;
        hw_level = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (bus.int_pending !== 1'b0) begin
            errors++;
            $display("FAIL int_clear got=%b want=0", bus.int_pending);
        end
    endtask

    task automatic test_directed();
        im_v = 8'h00;
        run_txn("ov", NEXC'(1) << 4, 32'h8000_1000, 1'b0, 32'h0, 2'b00, 3);
        run_txn("ri_ades_bd", (NEXC'(1) << 3) | (NEXC'(1) << 10), 32'hBFC0_0104, 1'b1,
                32'h1234_5678, 2'b00, 0);
        run_txn("tlbs_refill", NEXC'(1) << 12, 32'h8000_0040, 1'b0, 32'h0040_0008, 2'b00, 2);
        run_txn("eret", NEXC'(1) << 8, 32'h8000_0080, 1'b0, 32'h0, 2'b00, 1);
        run_txn("refetch", NEXC'(1) << 16, 32'h8000_00C0, 1'b0, 32'h0, 2'b00, 0);
    endtask

    task automatic test_random();
        logic [NEXC-1:0] vec;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0: vec = NEXC'(1) << $urandom_range(0, NEXC - 1);
                1: vec = NEXC'($urandom);
                2: vec = NEXC'($urandom) & 17'h1FF00;
                default: vec = NEXC'(1) << 16;
            endcase
            if (vec == '0) vec[16] = 1'b1;
            im_v = 8'h03; ie_v = 1'b1; exl_v = ($urandom_range(0, 3) == 0);
            run_txn($sformatf("rand%0d", n), vec, $urandom, 1'($urandom), $urandom,
                    2'($urandom_range(0, 3) == 0 ? $urandom : 0), $urandom_range(0, 3));
        end
    endtask

    task automatic test_perf();
        @(negedge clk);
`ifdef EXC_PERF_CNT_EN
        vectors++;
        if (bus.perf_exc_cnt !== 32'(exp_exc_cnt) || bus.perf_int_cnt !== 32'(exp_int_cnt)) begin
            errors++;
            $display("FAIL perf_cnt got exc=%0d int=%0d want exc=%0d int=%0d",
                     bus.perf_exc_cnt, bus.perf_int_cnt, exp_exc_cnt, exp_int_cnt);
        end
`else
        vectors++;
        if (bus.perf_exc_cnt !== 32'd0 || bus.perf_int_cnt !== 32'd0) begin
            errors++;
            $display("FAIL perf_tied got exc=%0d int=%0d want 0/0", bus.perf_exc_cnt, bus.perf_int_cnt);
        end
`endif
        $display("txn perf counters exc=%0d int=%0d", exp_exc_cnt, exp_int_cnt);
    endtask

    initial begin
        test_reset();
        test_stall_and_reset();
        test_directed();
        test_int_sync();
        test_random();
        test_perf();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
